// File: rtl/midi_pkg.sv
// Shared MIDI constants, message-length helper and FSM state types.
// The transmit and receive paths both import this package.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  // Serial frame states; ST_DONE marks end of a whole message.
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_DONE} state_e;

  // Message sequencer states in the writer top.
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_SEND, SEQ_DONE} seq_e;

  function automatic logic [1:0] msg_len(input logic [3:0] st);
    return (st == PROG || st == CHAN_AT) ? 2'd2 : 2'd3;
  endfunction

  function automatic logic status_ok(input logic [3:0] st);
    return st[3] && (st != 4'hF);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1 UART frame (start, 8 data bits LSB first, stop) per valid/ready handshake.
// Ready rises in the last stop cycle so the next byte follows with no idle gap.
module uart_tx_byte
  import midi_pkg::*;
#(
  parameter int BIT_CYC = 3200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] byte_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       done_o,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  assign bit_end = (baud_q == LAST);
  assign busy_o  = (state_q != ST_IDLE);
  assign tx_o    = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    ready_o = 1'b0;
    done_o  = 1'b0;
    if (state_q != ST_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        baud_d  = '0;
        if (valid_i) begin
          state_d = ST_START;
          sh_d    = byte_i;
          tx_d    = 1'b0;
        end
      end
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        bit_d   = 3'd0;
        tx_d    = sh_q[0];
      end
      ST_DATA: if (bit_end) begin
        // bit index wraps 7->0 naturally on the way into STOP
        sh_d  = {1'b0, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else begin
          tx_d = sh_q[1];
        end
      end
      ST_STOP: if (bit_end) begin
        ready_o = 1'b1;
        done_o  = 1'b1;
        if (valid_i) begin
          state_d = ST_START;
          sh_d    = byte_i;
          tx_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    sh_q <= sh_d;
  end

endmodule

// File: rtl/midi_writer.sv
// MIDI channel-voice message transmitter (31250 baud 8N1 over a UART pin).
// Optional running-status suppression: define MIDI_WRITER_RUNNING_STATUS_EN.
module midi_writer
  import midi_pkg::*;
#(
  parameter int         CLK_HZ  = 100_000_000,
  parameter int         BAUD    = 31250,
  parameter logic [3:0] CHANNEL = 4'h0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] status,
  input  logic [7:0] data_byte1,
  input  logic [7:0] data_byte2,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       err_out
);

  localparam int BIT_CYC = CLK_HZ / BAUD;

  seq_e            seq_q, seq_d;
  logic [1:0]      idx_q, idx_d, n_q, n_d;
  logic            err_q, err_d;
  logic [3:0][7:0] msg_q, msg_d;
  logic [7:0]      sb, d1, d2, tx_byte;
  logic            accept, ok, skip, tx_valid, tx_ready, tx_done;

  assign sb        = {status, CHANNEL};
  assign d1        = data_byte1 & 8'h7F;
  assign d2        = data_byte2 & 8'h7F;
  assign ready_out = (seq_q != SEQ_SEND);
  assign accept    = valid_in && ready_out;
  assign ok        = status_ok(status);
  assign done_out  = (seq_q == SEQ_DONE);
  assign err_out   = err_q;

`ifdef MIDI_WRITER_RUNNING_STATUS_EN
  // Zero never matches a real status byte (bit 7 is always set), so reset means "none sent".
  logic [7:0] last_q;
  assign skip = (sb == last_q);
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                   last_q <= 8'h00;
    else if (accept && ok && !skip) last_q <= sb;
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    seq_d    = seq_q;
    idx_d    = idx_q;
    n_d      = n_q;
    err_d    = 1'b0;
    msg_d    = msg_q;
    tx_valid = 1'b0;
    tx_byte  = msg_q[idx_q];
    case (seq_q)
      SEQ_IDLE, SEQ_DONE: begin
        seq_d = SEQ_IDLE;
        if (accept) begin
          if (ok) begin
            // First byte goes straight to the serializer so the start bit begins next cycle.
            seq_d    = SEQ_SEND;
            idx_d    = 2'd1;
            n_d      = msg_len(status) - {1'b0, skip};
            msg_d    = skip ? {8'h00, 8'h00, d2, d1} : {8'h00, d2, d1, sb};
            tx_valid = 1'b1;
            tx_byte  = msg_d[0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEQ_SEND: begin
        tx_valid = (idx_q != n_q);
        if (tx_valid && tx_ready) idx_d = idx_q + 2'd1;
        if (tx_done && !tx_valid) seq_d = SEQ_DONE;
      end
      default: seq_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      seq_q <= SEQ_IDLE;
      idx_q <= 2'd0;
      n_q   <= 2'd0;
      err_q <= 1'b0;
    end else begin
      seq_q <= seq_d;
      idx_q <= idx_d;
      n_q   <= n_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk_in) begin
    msg_q <= msg_d;
  end

  uart_tx_byte #(.BIT_CYC(BIT_CYC)) u_tx (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .byte_i  (tx_byte),
    .valid_i (tx_valid),
    .ready_o (tx_ready),
    .done_o  (tx_done),
    .busy_o  (busy_out),
    .tx_o    (tx_out)
  );

endmodule

// File: tb/tb_midi_writer.sv
// Bench for midi_writer: scoreboard of expected line bytes checked by a UART line monitor.
module tb_midi_writer;

  localparam int CLK_HZ = 500_000;
  localparam int BAUD   = 31250;
  localparam int B      = CLK_HZ / BAUD;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [3:0] status = 4'h0;
  logic [7:0] data_byte1 = 8'h00;
  logic [7:0] data_byte2 = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, tx_out, busy_out, done_out, err_out;

  midi_writer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(4'h0)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .status     (status),
    .data_byte1 (data_byte1),
    .data_byte2 (data_byte2),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .tx_out     (tx_out),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .err_out    (err_out)
  );

  always #5 clk_in = ~clk_in;

  int         n_chk = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         exp_done = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_sb = 8'h00;
  bit         rs_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (done_out) done_cnt++;
    if (err_out)  err_cnt++;
  end

  task automatic mon_wait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk_in);
      if (!rst_in) ab = 1'b1;
    end
  endtask

  // Line monitor: decode each frame at mid-bit and pop the scoreboard.
  initial begin : monitor
    logic [7:0] b;
    logic       st, sp;
    bit         ab;
    forever begin
      @(negedge clk_in);
      if (rst_in && tx_out === 1'b0) begin
        ab = 1'b0;
        mon_wait(B / 2, ab);
        st = tx_out;
        for (int i = 0; i < 8; i++) begin
          mon_wait(B, ab);
          b[i] = tx_out;
        end
        mon_wait(B, ab);
        sp = tx_out;
        if (!ab) begin
          chk("rx_start", {31'd0, st}, 32'd0);
          chk("rx_stop", {31'd0, sp}, 32'd1);
          chk("rx_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) chk("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send_msg(input logic [3:0] st, input logic [7:0] d1, input logic [7:0] d2,
                          input bit hold);
    logic [7:0] sb;
    int         len, n, cyc, bcnt;
    bit         skip;
    sb   = {st, 4'h0};
    len  = (st == 4'hC || st == 4'hD) ? 2 : 3;
    skip = rs_en && (sb == last_sb);
    if (!skip) begin
      exp_q.push_back(sb);
      last_sb = sb;
    end
    exp_q.push_back(d1 & 8'h7F);
    if (len == 3) exp_q.push_back(d2 & 8'h7F);
    n = skip ? len - 1 : len;
    status = st; data_byte1 = d1; data_byte2 = d2; valid_in = 1'b1;
    chk("ready_before", {31'd0, ready_out}, 32'd1);
    @(posedge clk_in); #1;
    if (!hold) valid_in = 1'b0;
    @(negedge clk_in);
    chk("start_next_cycle", {31'd0, tx_out}, 32'd0);
    chk("ready_low", {31'd0, ready_out}, 32'd0);
    chk("busy_high", {31'd0, busy_out}, 32'd1);
    cyc = 1; bcnt = 1;
    while (!done_out && cyc < 40 * B) begin
      @(negedge clk_in);
      cyc++;
      if (busy_out) bcnt++;
    end
    chk("done_seen", {31'd0, done_out}, 32'd1);
    chk("done_latency", cyc, n * 10 * B + 1);
    chk("busy_len", bcnt, n * 10 * B);
    chk("ready_on_done", {31'd0, ready_out}, 32'd1);
    chk("idle_on_done", {31'd0, tx_out}, 32'd1);
    exp_done++;
  endtask

  task automatic send_bad(input logic [3:0] st);
    bit quiet;
    status = st; data_byte1 = 8'h11; data_byte2 = 8'h22; valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    @(negedge clk_in);
    chk("err_pulse", {31'd0, err_out}, 32'd1);
    chk("err_ready", {31'd0, ready_out}, 32'd1);
    chk("err_line", {31'd0, tx_out}, 32'd1);
    @(negedge clk_in);
    chk("err_once", {31'd0, err_out}, 32'd0);
    quiet = 1'b1;
    repeat (2 * B) begin
      @(negedge clk_in);
      if (tx_out !== 1'b1 || ready_out !== 1'b1 || busy_out !== 1'b0 || done_out !== 1'b0)
        quiet = 1'b0;
    end
    chk("err_quiet", {31'd0, quiet}, 32'd1);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
`ifdef MIDI_WRITER_RUNNING_STATUS_EN
    rs_en = 1'b1;
`endif
    repeat (3) @(negedge clk_in);
    chk("rst_tx", {31'd0, tx_out}, 32'd1);
    chk("rst_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_busy", {31'd0, busy_out}, 32'd0);
    chk("rst_done", {31'd0, done_out}, 32'd0);
    chk("rst_err", {31'd0, err_out}, 32'd0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    send_msg(4'h9, 8'h3C, 8'h64, 1'b0);
    repeat (5) @(negedge clk_in);
    send_msg(4'hC, 8'h05, 8'h7F, 1'b0);
    send_bad(4'hF);
    send_bad(4'h3);
    send_msg(4'h8, 8'hFF, 8'h80, 1'b0);
    repeat (3) @(negedge clk_in);
    send_msg(4'h9, 8'h3C, 8'h64, 1'b1);
    send_msg(4'h9, 8'h3C, 8'h64, 1'b0);
    repeat (3) @(negedge clk_in);

    // Reset during the data bits of byte 2; only the first byte reaches the line.
    exp_q.push_back(8'hE0);
    status = 4'hE; data_byte1 = 8'h12; data_byte2 = 8'h34; valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    repeat (14 * B) @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx_out}, 32'd1);
    chk("midrst_ready", {31'd0, ready_out}, 32'd1);
    chk("midrst_busy", {31'd0, busy_out}, 32'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    last_sb = 8'h00;
    repeat (8 * B) @(negedge clk_in);
    chk("no_done_after_reset", done_cnt, exp_done);
    chk("idle_after_reset", {31'd0, tx_out}, 32'd1);
    send_msg(4'h9, 8'h40, 8'h7F, 1'b0);

    repeat (4 * B) @(negedge clk_in);
    chk("queue_empty", exp_q.size(), 0);
    chk("done_total", done_cnt, exp_done);
    chk("err_total", err_cnt, 2);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
